// File: rtl/pe_out_pkg.sv
// Shared constants for the PE transmit router: routing-word layout, source
// select codes and direction indices.
package pe_out_pkg;

    localparam int INST_W  = 16;
    localparam int NUM_DIR = 4;
    localparam int SEL_W   = 3;
    localparam int EN_LSB  = 12;

    // Direction index equals its enable bit offset and its sel field slot.
    localparam int DIR_N = 3;
    localparam int DIR_S = 2;
    localparam int DIR_W = 1;
    localparam int DIR_E = 0;

    localparam logic [SEL_W-1:0] SEL_R0   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_R1   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_R2   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_R3   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_RES  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_ZERO = 3'd5;

    function automatic int sel_lsb(input int dir);
        return dir * SEL_W;
    endfunction

endpackage

// File: rtl/pe_out_if.sv
// Bundle between the PE register file/ALU side and the router, plus the
// four neighbour link handshakes.
interface pe_out_if
    import pe_out_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STALL_W = 16
) ();

    logic [DATA_W-1:0]  din_R0;
    logic [DATA_W-1:0]  din_R1;
    logic [DATA_W-1:0]  din_R2;
    logic [DATA_W-1:0]  din_R3;
    logic [DATA_W-1:0]  din_res;
    logic [INST_W-1:0]  out_inst;
    logic               inst_valid;
    logic               inst_ready;
    logic [DATA_W-1:0]  dout_N;
    logic [DATA_W-1:0]  dout_S;
    logic [DATA_W-1:0]  dout_W;
    logic [DATA_W-1:0]  dout_E;
    logic               vld_N;
    logic               vld_S;
    logic               vld_W;
    logic               vld_E;
    logic               rdy_N;
    logic               rdy_S;
    logic               rdy_W;
    logic               rdy_E;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output din_R0, din_R1, din_R2, din_R3, din_res,
        output out_inst, inst_valid, rdy_N, rdy_S, rdy_W, rdy_E,
        input  inst_ready, dout_N, dout_S, dout_W, dout_E,
        input  vld_N, vld_S, vld_W, vld_E, stall_cnt
    );

    modport slave (
        input  din_R0, din_R1, din_R2, din_R3, din_res,
        input  out_inst, inst_valid, rdy_N, rdy_S, rdy_W, rdy_E,
        output inst_ready, dout_N, dout_S, dout_W, dout_E,
        output vld_N, vld_S, vld_W, vld_E, stall_cnt
    );

endinterface

// File: rtl/pe_out_router_chan.sv
// One-entry output stage for a single neighbour link with valid/ready.
module pe_out_chan #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              rdy,
    output logic [DATA_W-1:0] dout,
    output logic              vld,
    output logic              slot_free
);

    assign slot_free = !vld || rdy;

    // A load wins over a completing handshake so a draining slot refills
    // without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            dout <= load_data;
            vld  <= 1'b1;
        end else if (vld && rdy) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_out_router.sv
// PE transmit router: source mux, all-or-nothing issue and stall counter
// feeding four single-entry link stages.
module pe_out_router
    import pe_out_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STALL_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    pe_out_if.slave  bus
);

    logic [NUM_DIR-1:0] en;
    logic [NUM_DIR-1:0] rdy;
    logic [NUM_DIR-1:0] vld;
    logic [NUM_DIR-1:0] slot_free;
    logic [NUM_DIR-1:0] load;
    logic [DATA_W-1:0]  sel_word [NUM_DIR];
    logic [DATA_W-1:0]  dout     [NUM_DIR];
    logic               fire;
    logic [STALL_W-1:0] stall_cnt;

    assign en  = bus.out_inst[EN_LSB +: NUM_DIR];
    assign rdy = {bus.rdy_N, bus.rdy_S, bus.rdy_W, bus.rdy_E};

    always_comb begin
        for (int d = 0; d < NUM_DIR; d++) begin
            sel_word[d] = '0;
            case (bus.out_inst[sel_lsb(d) +: SEL_W])
                SEL_R0:  sel_word[d] = bus.din_R0;
                SEL_R1:  sel_word[d] = bus.din_R1;
                SEL_R2:  sel_word[d] = bus.din_R2;
                SEL_R3:  sel_word[d] = bus.din_R3;
                SEL_RES: sel_word[d] = bus.din_res;
                default: sel_word[d] = '0;
            endcase
        end
    end

    // Disabled directions never block, so a zero-enable word always issues.
    assign bus.inst_ready = &(slot_free | ~en);
    assign fire           = bus.inst_valid && bus.inst_ready;
    assign load           = {NUM_DIR{fire}} & en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (bus.inst_valid && !bus.inst_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt;

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_chan
        pe_out_chan #(.DATA_W(DATA_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load      (load[d]),
            .load_data (sel_word[d]),
            .rdy       (rdy[d]),
            .dout      (dout[d]),
            .vld       (vld[d]),
            .slot_free (slot_free[d])
        );
    end

    assign bus.dout_N = dout[DIR_N];
    assign bus.dout_S = dout[DIR_S];
    assign bus.dout_W = dout[DIR_W];
    assign bus.dout_E = dout[DIR_E];
    assign bus.vld_N  = vld[DIR_N];
    assign bus.vld_S  = vld[DIR_S];
    assign bus.vld_W  = vld[DIR_W];
    assign bus.vld_E  = vld[DIR_E];

endmodule

// File: tb/tb_pe_out_router.sv
// Self-checking bench for pe_out_router: directed scenarios plus random
// traffic against a per-link behavioural model.
module tb_pe_out_router;

    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int SAT = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_out_if #(.DATA_W(DW), .STALL_W(SW)) bus ();

    pe_out_router #(.DATA_W(DW), .STALL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus variables; direction index 3=N 2=S 1=W 0=E.
    logic [DW-1:0] r [4];
    logic [DW-1:0] res;
    logic [15:0]   inst;
    logic          iv;
    logic [3:0]    rdy;

    assign bus.din_R0     = r[0];
    assign bus.din_R1     = r[1];
    assign bus.din_R2     = r[2];
    assign bus.din_R3     = r[3];
    assign bus.din_res    = res;
    assign bus.out_inst   = inst;
    assign bus.inst_valid = iv;
    assign bus.rdy_N      = rdy[3];
    assign bus.rdy_S      = rdy[2];
    assign bus.rdy_W      = rdy[1];
    assign bus.rdy_E      = rdy[0];

    logic [3:0]    obs_vld;
    logic [DW-1:0] obs_dout [4];
    assign obs_vld     = {bus.vld_N, bus.vld_S, bus.vld_W, bus.vld_E};
    assign obs_dout[3] = bus.dout_N;
    assign obs_dout[2] = bus.dout_S;
    assign obs_dout[1] = bus.dout_W;
    assign obs_dout[0] = bus.dout_E;

    // Reference model: what each link currently holds and the stall count.
    bit            m_vld  [4];
    logic [DW-1:0] m_dat  [4];
    int            m_stall;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] src_of(input int code);
        logic [DW-1:0] w;
        if (code < 4)       w = r[code];
        else if (code == 4) w = res;
        else                w = '0;
        return w;
    endfunction

    function automatic bit exp_ready();
        bit ok = 1'b1;
        for (int d = 0; d < 4; d++)
            if (inst[12+d] && m_vld[d] && !rdy[d]) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 4; d++) begin
            m_vld[d] = 1'b0;
            m_dat[d] = '0;
        end
        m_stall = 0;
    endtask

    // One clock: check at the falling edge, advance the model, return 1 after the rising edge.
    task automatic cycle();
        bit go;
        @(negedge clk);
        go = iv && exp_ready();
        check_val("inst_ready", {31'd0, bus.inst_ready}, {31'd0, exp_ready()});
        check_val("stall_cnt", {28'd0, bus.stall_cnt}, m_stall);
        for (int d = 0; d < 4; d++) begin
            check_val($sformatf("vld_%0d", d), {31'd0, obs_vld[d]}, {31'd0, m_vld[d]});
            check_val($sformatf("dout_%0d", d), obs_dout[d], m_dat[d]);
        end
        if (iv && !go && m_stall < SAT) m_stall++;
        for (int d = 0; d < 4; d++) begin
            if (go && inst[12+d]) begin
                m_dat[d] = src_of(int'(inst[d*3 +: 3]));
                m_vld[d] = 1'b1;
            end else if (m_vld[d] && rdy[d]) begin
                m_vld[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        iv  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check_val("rst_stall", {28'd0, bus.stall_cnt}, 0);
        check_val("rst_vld", {28'd0, obs_vld}, 0);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) r[i] = '0;
        res  = '0;
        inst = '0;
        iv   = 1'b0;
        rdy  = 4'hF;
        model_clear();
        do_reset();
        check_val("rst_dout_N", bus.dout_N, 0);
        check_val("rst_ready", {31'd0, bus.inst_ready}, 1);

        // Broadcast R0 to all four links.
        r[0] = 32'hA5; inst = 16'hF000; iv = 1'b1; rdy = 4'hF;
        cycle();
        iv = 1'b0;
        for (int d = 0; d < 4; d++) check_val("bcast_dout", obs_dout[d], 32'hA5);
        check_val("bcast_vld", {28'd0, obs_vld}, 32'hF);
        cycle();
        check_val("bcast_drain", {28'd0, obs_vld}, 0);

        // N stalled for three cycles behind a held result word.
        do_reset();
        res = 32'h1234; inst = 16'h8800; iv = 1'b1; rdy = 4'b0111;
        cycle();
        res = 32'h5678;
        repeat (3) cycle();
        check_val("stall3_cnt", {28'd0, bus.stall_cnt}, 3);
        check_val("stall3_dout", bus.dout_N, 32'h1234);
        check_val("stall3_vld", {31'd0, bus.vld_N}, 1);
        rdy = 4'hF;
        cycle();
        iv = 1'b0;
        check_val("stall3_next", bus.dout_N, 32'h5678);
        cycle();

        // All-or-nothing: blocked N keeps E idle.
        do_reset();
        res = 32'h11; inst = 16'h8800; iv = 1'b1; rdy = 4'b0111;
        cycle();
        r[2] = 32'h22; inst = 16'h9002; // en N,E; sel_N=R0, sel_E=R2
        repeat (2) cycle();
        check_val("aon_E_idle", {31'd0, bus.vld_E}, 0);
        rdy = 4'hF;
        cycle();
        iv = 1'b0;
        check_val("aon_E_go", bus.dout_E, 32'h22);
        check_val("aon_E_vld", {31'd0, bus.vld_E}, 1);
        cycle();

        // Back-to-back on W from R1.
        do_reset();
        inst = 16'h2008; iv = 1'b1; rdy = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            r[1] = k;
            cycle();
            check_val("b2b_dout_W", bus.dout_W, k);
            check_val("b2b_vld_W", {31'd0, bus.vld_W}, 1);
        end
        iv = 1'b0;
        cycle();

        // Zero-word selects on S, then a zero-enable instruction.
        do_reset();
        for (int i = 0; i < 4; i++) r[i] = 32'hDEAD_0000 + i + 1;
        res = 32'hBEEF;
        iv = 1'b1; rdy = 4'hF;
        for (int k = 5; k <= 7; k++) begin
            inst = 16'h4040; // sel_S=R1: nonzero
            cycle();
            inst = 16'h4000 | 16'(k << 6);
            cycle();
            check_val("zero_dout_S", bus.dout_S, 0);
            check_val("zero_vld_S", {31'd0, bus.vld_S}, 1);
        end
        inst = 16'h0FFF;
        cycle();
        cycle();
        check_val("zen_vld", {28'd0, obs_vld}, 0);
        iv = 1'b0;

        // Saturation, then asynchronous reset mid-stall.
        do_reset();
        res = 32'h77; inst = 16'h8800; iv = 1'b1; rdy = 4'b0111;
        cycle();
        repeat (20) cycle();
        check_val("sat_cnt", {28'd0, bus.stall_cnt}, SAT);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_vld", {28'd0, obs_vld}, 0);
        check_val("arst_cnt", {28'd0, bus.stall_cnt}, 0);
        check_val("arst_dout", bus.dout_N, 0);
        iv = 1'b0;
        do_reset();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            inst = 16'($urandom);
            rdy  = 4'($urandom);
            for (int i = 0; i < 4; i++) r[i] = $urandom;
            res  = $urandom;
            cycle();
        end
        iv = 1'b0;
        rdy = 4'hF;
        cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_out_router.md
Name: pe_out_router

Overview:
- Transmit-side counterpart of the PE register file.
- Takes the four register outputs R0..R3 and the ALU result, and drives them onto the N/S/W/E neighbour links under a per-instruction routing word.
- Each direction link has a one-entry output stage with a valid/ready handshake, so a stalled neighbour back-pressures instruction issue.
- Sits between the PE register file/ALU and the inter-PE interconnect.

Parameters:
- DATA_W, 32, data width of registers, result and links
- STALL_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- din_R0  in  DATA_W  register file R0
- din_R1  in  DATA_W  register file R1
- din_R2  in  DATA_W  register file R2
- din_R3  in  DATA_W  register file R3
- din_res  in  DATA_W  ALU result
- out_inst  in  16  routing word (format below)
- inst_valid  in  1  out_inst is valid
- inst_ready  out  1  instruction accepted this cycle when high with inst_valid
- dout_N/dout_S/dout_W/dout_E  out  DATA_W each  link data
- vld_N/vld_S/vld_W/vld_E  out  1 each  link data valid
- rdy_N/rdy_S/rdy_W/rdy_E  in  1 each  neighbour accepts data
- stall_cnt  out  STALL_W  cycles with inst_valid high and inst_ready low, saturating

Behaviour:
- out_inst fields:
  - [15:12] = enable {N,S,W,E}
  - [11:9] = sel_N, [8:6] = sel_S, [5:3] = sel_W, [2:0] = sel_E
- sel codes: 0=R0, 1=R1, 2=R2, 3=R3, 4=din_res, 5..7 = all-zero word.
- Per direction d: slot_free_d = !vld_d || rdy_d.
- inst_ready (combinational) = AND of slot_free_d over enabled directions. With no directions enabled, inst_ready = 1.
- fire = inst_valid && inst_ready.
- On fire, each enabled direction samples the selected source as presented in the fire cycle:
  - dout_d <= src, vld_d <= 1 at the next edge (latency 1).
  - If the slot was draining (vld_d && rdy_d), the new word replaces it back-to-back with no bubble.
- Direction not enabled, or no fire:
  - vld_d && rdy_d -> vld_d <= 0, dout_d holds its last value.
  - vld_d && !rdy_d -> dout_d and vld_d hold stable (protocol rule: data never changes while valid and not ready).
- Issue is all-or-nothing. A stall on any enabled direction blocks the whole instruction; no partial issue.
  - Unenabled directions keep draining independently while an instruction is blocked.
- Zero-enable instruction: fires in one cycle, no link activity. Counts as a fire, so it adds no stall cycle.
- stall_cnt:
  - +1 on each cycle with inst_valid && !inst_ready.
  - Saturates at 2^STALL_W-1; never wraps.
- rdy_d is ignored while vld_d = 0.
- Reset (rst low, asynchronous):
  - All vld_* = 0, all dout_* = 0, stall_cnt = 0.
  - Pending link words are dropped.
  - inst_ready while in reset = 1 only via its combinational definition; sources must not issue during reset.
  - Deassertion is synchronised externally.
- Simultaneous fire with rdy high and vld high on the same direction: handshake completes and the new word loads in the same edge.

Decomposition:
- Shared package pe_out_pkg: sel code constants (SEL_R0..SEL_RES, SEL_ZERO), out_inst field bit positions, direction index constants N=3, S=2, W=1, E=0 (matching enable bit order).
- One sub-module: pe_out_chan, a single-direction output stage with inputs load, load_data, rdy and outputs dout, vld, slot_free. It is instantiated four times; the top holds the source mux, issue logic and stall counter.

Test Plan:
- Reset, then out_inst=16'hF_000 style {en=4'b1111, all sel=0}, R0=32'hA5 with all rdy=1 -> next cycle dout_N=dout_S=dout_W=dout_E=32'hA5, all vld=1; after one more idle cycle all vld=0.
- en=4'b1000, sel_N=4, din_res=32'h1234 with rdy_N=0 held 3 cycles, then a second inst on N -> dout_N stays 32'h1234 with vld_N=1. inst_ready=0 for 3 cycles and stall_cnt=3. The second word appears the cycle after rdy_N=1.
- N blocked (rdy_N=0, vld_N=1), then inst en=4'b1001 (N and E) -> no issue on E either; E stays idle until N drains (all-or-nothing).
- Back-to-back: rdy_W=1, inst_valid every cycle with en=4'b0010, sel_W=1, R1=1,2,3,4 -> dout_W=1,2,3,4 on consecutive cycles, vld_W continuously 1.
- sel=5..7 on S with R values nonzero -> dout_S=0, vld_S=1. Zero-enable inst -> inst_ready=1, no vld change.
- Hold inst blocked with STALL_W=4 for 20 cycles -> stall_cnt saturates at 15. Assert rst low mid-stall -> vld_* and stall_cnt cleared immediately, without waiting for a clock edge.
